// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the memory bus responder.
// Imported by mem_array and mem_bus_responder.
package mem_bus_pkg;

    localparam int DATA_W = 16;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word RAM, DEPTH x DATA_W, registered read, no reset.
// Ports: clk, we (write enable), addr (word index), din (write data), dout (read data).
module mem_array
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-before-write: dout shows the old word on a write cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: captures one MREQ_N access, waits WAIT_STATES
// cycles, performs it on mem_array and runs a four-phase ACK handshake.
// Ports: clk, reset (sync, active high), MREQ_N, R_W_N, addr, wdata in;
//        rdata, ACK, ERR (out-of-range, only with ACK) out.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MREQ_N,
    input  logic              R_W_N,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ACK,
    output logic              ERR
);

    localparam int AW = $clog2(DEPTH);

    mem_state_t        state;
    logic [WAIT_W-1:0] cnt;
    logic              rw_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              in_range;
    logic              complete;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_dout;

    assign in_range = (addr_q >> AW) == '0;
    assign complete = (state == BUSY) && !MREQ_N && (cnt == '0);
    assign ram_we   = complete && !rw_q && in_range && !reset;

    // In IDLE the RAM is addressed with the live bus address so the
    // registered read is already valid one edge after capture; this is
    // what lets a zero-wait read complete at E1 with correct data.
    assign ram_addr = (state == IDLE) ? addr[AW-1:0] : addr_q[AW-1:0];

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            ACK     <= 1'b0;
            ERR     <= 1'b0;
            rdata   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!MREQ_N) begin
                        rw_q    <= R_W_N;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= WAIT_W'(WAIT_STATES);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (MREQ_N) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        ACK   <= 1'b1;
                        ERR   <= !in_range;
                        state <= DONE;
                        if (rw_q) begin
                            rdata <= in_range ? ram_dout : '0;
                        end
                    end
                end
                DONE: begin
                    if (MREQ_N) begin
                        ACK   <= 1'b0;
                        ERR   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: one DUT with 2 wait states,
// one with 0 wait states, sharing clock, reset and address/data lines.
module tb_mem_bus_responder;

    typedef struct {
        bit          rd;
        bit          err;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  mreq_n;
    logic        r_w_n;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic [1:0]  ack;
    logic [1:0]  err;

    int tests = 0;
    int fails = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] mm[int];
    logic [15:0] last_rd[2];
    logic [1:0]  ack_p;

    mem_bus_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .MREQ_N (mreq_n[0]),
        .R_W_N  (r_w_n),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata0),
        .ACK    (ack[0]),
        .ERR    (err[0])
    );

    mem_bus_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk    (clk),
        .reset  (reset),
        .MREQ_N (mreq_n[1]),
        .R_W_N  (r_w_n),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata1),
        .ACK    (ack[1]),
        .ERR    (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rd_of(input int d);
        return (d == 0) ? rdata0 : rdata1;
    endfunction

    // Monitor: every rising ACK completes the oldest outstanding access.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack[d] && !ack_p[d]) begin
                exp_t e;
                if ((d == 0 && q0.size() == 0) ||
                    (d == 1 && q1.size() == 0)) begin
                    check($sformatf("unexpected_ack%0d", d), 1, 0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("err%0d", d), {31'd0, err[d]},
                          {31'd0, e.err});
                    check($sformatf("rdata%0d", d), {16'd0, rd_of(d)},
                          {16'd0, e.data});
                end
            end
            if (err[d] && !ack[d]) begin
                check($sformatf("err_without_ack%0d", d), 1, 0);
            end
        end
        ack_p = ack;
    end

    // Reference model: word RAM per DUT, DEPTH 256, rdata tracks last read.
    task automatic access(input int d, input bit rd, input logic [15:0] a,
                          input logic [15:0] wd);
        exp_t e;
        int   key;
        int   k;
        key   = d * 65536 + int'(a);
        e.rd  = rd;
        e.err = (a >= 16'd256);
        if (rd) begin
            e.data     = e.err ? 16'h0000 : mm[key];
            last_rd[d] = e.data;
        end else begin
            e.data = last_rd[d];
            if (!e.err) mm[key] = wd;
        end
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);

        @(negedge clk);
        addr      = a;
        wdata     = wd;
        r_w_n     = rd;
        mreq_n[d] = 1'b0;
        @(posedge clk);
        #1;
        addr  = 16'($urandom);
        wdata = 16'($urandom);
        r_w_n = ~rd;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (!ack[d] && k < 40);
        check($sformatf("latency%0d", d), k, (d == 0) ? 3 : 1);
        if (!ack[d]) begin
            if (d == 0) void'(q0.pop_back());
            else        void'(q1.pop_back());
        end
        mreq_n[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("ack_fall%0d", d), {31'd0, ack[d]}, 0);
    endtask

    initial begin
        reset   = 1'b1;
        mreq_n  = 2'b11;
        r_w_n   = 1'b1;
        addr    = '0;
        wdata   = '0;
        ack_p   = 2'b00;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", {30'd0, ack}, 0);
        check("reset_err", {30'd0, err}, 0);
        check("reset_rdata0", {16'd0, rdata0}, 0);
        check("reset_rdata1", {16'd0, rdata1}, 0);
        reset = 1'b0;

        for (int a = 0; a < 32; a++) begin
            access(0, 1'b0, 16'(a), 16'($urandom));
            access(1, 1'b0, 16'(a), 16'($urandom));
        end

        access(0, 1'b0, 16'h0012, 16'hBEEF);
        access(0, 1'b1, 16'h0012, 16'h0000);
        access(1, 1'b1, 16'h0001, 16'h0000);
        access(1, 1'b1, 16'h0001, 16'h0000);

        access(0, 1'b0, 16'h0100, 16'h1234);
        access(0, 1'b1, 16'h0000, 16'h0000);
        access(0, 1'b1, 16'h0100, 16'h0000);
        access(1, 1'b0, 16'hFFFF, 16'h1234);
        access(1, 1'b1, 16'h0100, 16'h0000);

        // Abort a write after one BUSY cycle.
        @(negedge clk);
        addr      = 16'h0005;
        wdata     = 16'hAAAA;
        r_w_n     = 1'b0;
        mreq_n[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        mreq_n[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_ack", {31'd0, ack[0]}, 0);
        end
        access(0, 1'b1, 16'h0005, 16'h0000);

        // Reset during BUSY of a write drops it.
        @(negedge clk);
        addr      = 16'h0003;
        wdata     = 16'h5555;
        r_w_n     = 1'b0;
        mreq_n[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        mreq_n[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_ack", {31'd0, ack[0]}, 0);
        check("rst_mid_err", {31'd0, err[0]}, 0);
        check("rst_mid_rdata0", {16'd0, rdata0}, 0);
        check("rst_mid_rdata1", {16'd0, rdata1}, 0);
        reset      = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        access(0, 1'b1, 16'h0003, 16'h0000);
        access(1, 1'b0, 16'h0007, 16'h0BAD);

        for (int i = 0; i < 80; i++) begin
            int          d;
            bit          rd;
            logic [15:0] a;
            d  = int'($urandom_range(0, 1));
            rd = 1'($urandom);
            if ($urandom_range(0, 7) == 0)
                a = 16'(256 + $urandom_range(0, 65279));
            else
                a = 16'($urandom_range(0, 31));
            access(d, rd, a, 16'($urandom));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
